// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter that shares one iterative AES core among NumReq requesters,
// with bounded per-owner bursts and a single job in flight.
module aes_req_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned MaxBurst = 4,
    localparam int unsigned IdxW    = $clog2(NumReq)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0]       req_op_i,
    input  logic [NumReq-1:0]       req_last_i,
    input  logic [NumReq*128-1:0]   req_data_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output logic [127:0]            rsp_data_o,
    output logic                    cipher_in_valid_o,
    input  logic                    cipher_in_ready_i,
    output logic                    cipher_op_o,
    output logic [127:0]            cipher_state_o,
    input  logic                    cipher_out_valid_i,
    output logic                    cipher_out_ready_o,
    input  logic [127:0]            cipher_state_i,
    output logic                    busy_o,
    output logic [IdxW-1:0]         owner_o
);

    localparam int unsigned CntW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lock_q, lock_d;
    logic            op_q, op_d;
    logic            last_q, last_d;
    logic [127:0]    data_q, data_d;
    logic [127:0]    rsp_data_q, rsp_data_d;

    logic            win_found;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] search_base;
    logic [IdxW-1:0] owner_inc;
    logic [IdxW-1:0] cand;

    assign owner_inc = IdxW'((32'(owner_q) + 1) % NumReq);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            lock_q     <= 1'b0;
            op_q       <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            lock_q     <= lock_d;
            op_q       <= op_d;
            last_q     <= last_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
        op_d        = op_q;
        last_d      = last_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        win_found   = 1'b0;
        win_idx     = '0;
        search_base = ptr_q;
        cand        = '0;

        unique case (state_q)
            IDLE: begin
                if (lock_q && req_valid_i[owner_q]) begin
                    win_found = 1'b1;
                    win_idx   = owner_q;
                end else begin
                    // A dropped lock restarts the round just past the old owner.
                    lock_d = 1'b0;
                    if (lock_q) begin
                        search_base = owner_inc;
                        ptr_d       = owner_inc;
                        cnt_d       = '0;
                    end
                    for (int unsigned i = 0; i < NumReq; i++) begin
                        cand = IdxW'((32'(search_base) + i) % NumReq);
                        if (!win_found && req_valid_i[cand]) begin
                            win_found = 1'b1;
                            win_idx   = cand;
                        end
                    end
                end
                if (win_found) begin
                    op_d    = req_op_i[win_idx];
                    last_d  = req_last_i[win_idx];
                    data_d  = req_data_i[32'(win_idx)*128 +: 128];
                    owner_d = win_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (cipher_in_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cipher_out_valid_i) begin
                    rsp_data_d = cipher_state_i;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                    if (!last_q && (32'(cnt_q) + 1 < MaxBurst)) begin
                        lock_d = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        lock_d = 1'b0;
                        cnt_d  = '0;
                        ptr_d  = owner_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        // Grant is masked during reset so every output reads 0 while rst_ni is low.
        if (state_q == IDLE && win_found && rst_ni) begin
            req_ready_o[win_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
        cipher_in_valid_o  = (state_q == SEND);
        cipher_out_ready_o = (state_q == WAIT);
        busy_o             = (state_q != IDLE);
        cipher_op_o        = op_q;
        cipher_state_o     = data_q;
        rsp_data_o         = rsp_data_q;
        owner_o            = owner_q;
    end

endmodule
